// File: rtl/jtframe_sndcmd_fifo_pkg.sv
`default_nettype none
// ==== jtframe_snd_pkg: shared constants for the sound command FIFO (rev 1.0) ====
package jtframe_snd_pkg;
   localparam int IRQ_EDGE  = 0;
   localparam int IRQ_LEVEL = 1;
   // status bit offsets, counted upward from the top of the count field
   localparam int ST_EMPTY  = 0;
   localparam int ST_FULL   = 1;
   localparam int ST_OVF    = 2;
endpackage
`default_nettype wire

// File: rtl/jtframe_sndcmd_fifo_if.sv
`default_nettype none
// ==== jtframe_sndcmd_fifo_if: main/sound CPU bus bundle for the command FIFO (rev 1.0) ====
interface jtframe_sndcmd_fifo_if #(
   parameter int DW = 8,
   parameter int AW = 2
);
   import jtframe_snd_pkg::*;
   localparam int SW = AW + ST_OVF + 1;

   logic          main_we;
   logic [DW-1:0] main_din;
   logic          main_rd;
   logic [DW-1:0] main_dout;
   logic          main_rdy;
   logic          main_full;
   logic          snd_rd;
   logic [DW-1:0] snd_dout;
   logic          snd_we;
   logic [DW-1:0] snd_din;
   logic          snd_stat_rd;
   logic [SW-1:0] snd_status;
   logic          irq_ack;
   logic          int_n;

   modport master (
      output main_we, main_din, main_rd, snd_rd, snd_we, snd_din, snd_stat_rd, irq_ack,
      input  main_dout, main_rdy, main_full, snd_dout, snd_status, int_n
   );

   modport slave (
      input  main_we, main_din, main_rd, snd_rd, snd_we, snd_din, snd_stat_rd, irq_ack,
      output main_dout, main_rdy, main_full, snd_dout, snd_status, int_n
   );
endinterface
`default_nettype wire

// File: rtl/jtframe_sndcmd_fifo_edge2.sv
`default_nettype none
// ==== jtframe_edge2: registered rise/fall strobe detector (rev 1.0) ====
module jtframe_edge2 (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise,
   output logic fall
);
   logic din_q, din_d;
   logic armed_q, armed_d;

   // a strobe already high when reset lifts is ignored until it has gone low once
   always_comb begin
      din_d   = din;
      armed_d = armed_q | ~din;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         din_q   <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         din_q   <= din_d;
         armed_q <= armed_d;
      end
   end

   assign rise =  din & ~din_q & armed_q;
   assign fall = ~din &  din_q & armed_q;
endmodule
`default_nettype wire

// File: rtl/jtframe_sndcmd_fifo.sv
`default_nettype none
// ==== jtframe_sndcmd_fifo: main-to-sound command FIFO with IRQ and reply latch (rev 1.0) ====
module jtframe_sndcmd_fifo
   import jtframe_snd_pkg::*;
#(
   parameter int          DW        = 8,
   parameter int          AW        = 2,
   parameter int          IRQ_MODE  = IRQ_EDGE,
   parameter int unsigned EMPTY_VAL = 8'hFF
)(
   input  logic                 clk,
   input  logic                 rst,
   jtframe_sndcmd_fifo_if.slave bus
);
   localparam int            PW      = (AW > 0) ? AW : 1;
   localparam int            SLOTS   = 1 << PW;
   localparam int            DEPTH   = 1 << AW;
   localparam logic [AW:0]   C_DEPTH = DEPTH[AW:0];
   localparam logic [DW-1:0] C_EMPTY = EMPTY_VAL[DW-1:0];

   logic          push_ev, pop_ev, stat_fall, mrd_fall, swe_rise;
   logic [4:0]    unused_edge;
   logic          do_push, do_pop, full, empty;

   logic [DW-1:0] mem_q [SLOTS];
   logic [DW-1:0] mem_d [SLOTS];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          ovf_q, ovf_d;
   logic [DW-1:0] main_dout_q, main_dout_d;
   logic          main_rdy_q, main_rdy_d;

   jtframe_edge2 u_main_we  (.clk(clk), .rst(rst), .din(bus.main_we),     .rise(push_ev),  .fall(unused_edge[0]));
   jtframe_edge2 u_main_rd  (.clk(clk), .rst(rst), .din(bus.main_rd),     .rise(unused_edge[1]), .fall(mrd_fall));
   jtframe_edge2 u_snd_rd   (.clk(clk), .rst(rst), .din(bus.snd_rd),      .rise(unused_edge[2]), .fall(pop_ev));
   jtframe_edge2 u_snd_we   (.clk(clk), .rst(rst), .din(bus.snd_we),      .rise(swe_rise), .fall(unused_edge[3]));
   jtframe_edge2 u_stat_rd  (.clk(clk), .rst(rst), .din(bus.snd_stat_rd), .rise(unused_edge[4]), .fall(stat_fall));

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (AW == 0) ? '0 : p + 1'b1;
   endfunction

   assign full  = (count_q == C_DEPTH);
   assign empty = (count_q == '0);

   // a pop frees the slot a same-clock push into a full FIFO needs
   always_comb begin
      do_pop   = pop_ev & ~empty;
      do_push  = push_ev & (~full | do_pop);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = bus.main_din;
         wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop)
         rd_ptr_d = ptr_inc(rd_ptr_q);
      if (do_push & ~do_pop)
         count_d = count_q + 1'b1;
      else if (do_pop & ~do_push)
         count_d = count_q - 1'b1;
      if (stat_fall)
         ovf_d = 1'b0;
      if (push_ev & full & ~do_pop)
         ovf_d = 1'b1;
   end

   always_comb begin
      main_dout_d = main_dout_q;
      main_rdy_d  = main_rdy_q;
      if (mrd_fall)
         main_rdy_d = 1'b0;
      if (swe_rise) begin
         main_dout_d = bus.snd_din;
         main_rdy_d  = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q       <= '{default: '0};
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         ovf_q       <= 1'b0;
         main_dout_q <= '0;
         main_rdy_q  <= 1'b0;
      end else begin
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         ovf_q       <= ovf_d;
         main_dout_q <= main_dout_d;
         main_rdy_q  <= main_rdy_d;
      end
   end

   assign bus.snd_dout  = empty ? C_EMPTY : mem_q[rd_ptr_q];
   assign bus.main_dout = main_dout_q;
   assign bus.main_rdy  = main_rdy_q;
   assign bus.main_full = full;

   generate
      if (AW > 0) begin : g_status_cnt
         assign bus.snd_status = {ovf_q, full, empty, count_q[AW-1:0]};
      end else begin : g_status_nocnt
         assign bus.snd_status = {ovf_q, full, empty};
      end

      if (IRQ_MODE == IRQ_LEVEL) begin : g_irq_level
         logic int_n_q, int_n_d;
         logic unused_ack;
         assign unused_ack = bus.irq_ack;
         always_comb int_n_d = empty;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) int_n_q <= 1'b1;
            else     int_n_q <= int_n_d;
         end
         assign bus.int_n = int_n_q;
      end else begin : g_irq_edge
         logic pending_q, pending_d;
         // a push landing with the acknowledge keeps the request alive
         always_comb begin
            pending_d = pending_q;
            if (bus.irq_ack) pending_d = 1'b0;
            if (push_ev)     pending_d = 1'b1;
         end
         always_ff @(posedge clk or posedge rst) begin
            if (rst) pending_q <= 1'b0;
            else     pending_q <= pending_d;
         end
         assign bus.int_n = ~pending_q;
      end
   endgenerate
endmodule
`default_nettype wire

// File: tb/tb_jtframe_sndcmd_fifo.sv
`default_nettype none
// ==== tb_jtframe_sndcmd_fifo: directed bench for the sound command FIFO (rev 1.0) ====
module tb_jtframe_sndcmd_fifo;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   jtframe_sndcmd_fifo_if #(.DW(8), .AW(2)) if0 ();
   jtframe_sndcmd_fifo_if #(.DW(8), .AW(2)) if1 ();
   jtframe_sndcmd_fifo_if #(.DW(8), .AW(0)) if2 ();

   jtframe_sndcmd_fifo #(.DW(8), .AW(2), .IRQ_MODE(0), .EMPTY_VAL(8'hFF)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
   jtframe_sndcmd_fifo #(.DW(8), .AW(2), .IRQ_MODE(1), .EMPTY_VAL(8'hFF)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
   jtframe_sndcmd_fifo #(.DW(8), .AW(0), .IRQ_MODE(0), .EMPTY_VAL(8'hFF)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_all();
      {if0.main_we, if0.main_rd, if0.snd_rd, if0.snd_we, if0.snd_stat_rd, if0.irq_ack} = '0;
      {if1.main_we, if1.main_rd, if1.snd_rd, if1.snd_we, if1.snd_stat_rd, if1.irq_ack} = '0;
      {if2.main_we, if2.main_rd, if2.snd_rd, if2.snd_we, if2.snd_stat_rd, if2.irq_ack} = '0;
      {if0.main_din, if0.snd_din, if1.main_din, if1.snd_din, if2.main_din, if2.snd_din} = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_all();
      tick(2);
      rst = 1'b0;
      tick(3);
   endtask

   task automatic set_we(input int d, input logic v, input logic [7:0] b);
      case (d)
         0: begin if0.main_din = b; if0.main_we = v; end
         1: begin if1.main_din = b; if1.main_we = v; end
         default: begin if2.main_din = b; if2.main_we = v; end
      endcase
   endtask

   task automatic set_rd(input int d, input logic v);
      case (d)
         0: if0.snd_rd = v;
         1: if1.snd_rd = v;
         default: if2.snd_rd = v;
      endcase
   endtask

   task automatic push(input int d, input logic [7:0] b);
      set_we(d, 1'b1, b);
      tick(2);
      set_we(d, 1'b0, b);
      tick(2);
   endtask

   task automatic pop(input int d, output logic [7:0] v);
      set_rd(d, 1'b1);
      tick(1);
      case (d)
         0: v = if0.snd_dout;
         1: v = if1.snd_dout;
         default: v = if2.snd_dout;
      endcase
      tick(1);
      set_rd(d, 1'b0);
      tick(2);
   endtask

   task automatic test_reset();
      do_reset();
      if (if0.int_n !== 1'b1) begin bad++; $display("FAIL rst_int_n got=%b exp=1", if0.int_n); end
      total++;
      if (if0.main_rdy !== 1'b0 || if0.main_dout !== 8'h00) begin bad++; $display("FAIL rst_reply got=%b/%h exp=0/00", if0.main_rdy, if0.main_dout); end
      total++;
      if (if0.main_full !== 1'b0) begin bad++; $display("FAIL rst_full got=%b exp=0", if0.main_full); end
      total++;
      if (if0.snd_dout !== 8'hFF) begin bad++; $display("FAIL rst_snd_dout got=%h exp=ff", if0.snd_dout); end
      total++;
      if (if0.snd_status !== 5'b00100) begin bad++; $display("FAIL rst_status got=%b exp=00100", if0.snd_status); end
      total++;
   endtask

   task automatic test_push_pop_irq();
      logic [7:0] v;
      logic [7:0] exp_q [3] = '{8'h11, 8'h22, 8'h33};
      do_reset();
      set_we(0, 1'b1, 8'h11);
      tick(1);
      if (if0.int_n !== 1'b0) begin bad++; $display("FAIL irq_set got=%b exp=0", if0.int_n); end
      total++;
      if (if0.snd_dout !== 8'h11) begin bad++; $display("FAIL head_first got=%h exp=11", if0.snd_dout); end
      total++;
      tick(1);
      set_we(0, 1'b0, 8'h11);
      tick(2);
      push(0, 8'h22);
      push(0, 8'h33);
      if (if0.snd_status !== 5'b00011) begin bad++; $display("FAIL status_cnt3 got=%b exp=00011", if0.snd_status); end
      total++;
      if0.irq_ack = 1'b1;
      tick(1);
      if0.irq_ack = 1'b0;
      tick(1);
      if (if0.int_n !== 1'b1) begin bad++; $display("FAIL irq_ack got=%b exp=1", if0.int_n); end
      total++;
      for (int i = 0; i < 3; i++) begin
         pop(0, v);
         if (v !== exp_q[i]) begin bad++; $display("FAIL pop_%0d got=%h exp=%h", i, v, exp_q[i]); end
         total++;
      end
      if (if0.snd_dout !== 8'hFF || if0.snd_status !== 5'b00100) begin bad++; $display("FAIL drained got=%h/%b exp=ff/00100", if0.snd_dout, if0.snd_status); end
      total++;
   endtask

   task automatic test_overflow();
      logic [7:0] v;
      do_reset();
      for (int i = 1; i <= 4; i++) begin
         push(0, 8'(i));
         if (if0.main_full !== (i == 4)) begin bad++; $display("FAIL full_after_%0d got=%b exp=%b", i, if0.main_full, (i == 4)); end
         total++;
      end
      push(0, 8'h05);
      if (if0.snd_status !== 5'b11000) begin bad++; $display("FAIL ovf_status got=%b exp=11000", if0.snd_status); end
      total++;
      if0.snd_stat_rd = 1'b1;
      tick(1);
      if (if0.snd_status !== 5'b11000) begin bad++; $display("FAIL ovf_hold_during_rd got=%b exp=11000", if0.snd_status); end
      total++;
      tick(1);
      if0.snd_stat_rd = 1'b0;
      tick(1);
      if (if0.snd_status !== 5'b01000) begin bad++; $display("FAIL ovf_clear got=%b exp=01000", if0.snd_status); end
      total++;
      for (int i = 1; i <= 4; i++) begin
         pop(0, v);
         if (v !== 8'(i)) begin bad++; $display("FAIL ovf_pop_%0d got=%h exp=%h", i, v, 8'(i)); end
         total++;
      end
      if (if0.snd_status !== 5'b00100) begin bad++; $display("FAIL ovf_drained got=%b exp=00100", if0.snd_status); end
      total++;
   endtask

   task automatic test_back_to_back();
      logic [7:0] v;
      logic [7:0] exp_q [4] = '{8'h02, 8'h03, 8'h04, 8'h55};
      do_reset();
      for (int i = 1; i <= 4; i++) push(0, 8'(i));
      set_rd(0, 1'b1);
      tick(2);
      set_rd(0, 1'b0);
      set_we(0, 1'b1, 8'h55);
      tick(1);
      if (if0.snd_status !== 5'b01000) begin bad++; $display("FAIL b2b_status got=%b exp=01000", if0.snd_status); end
      total++;
      if (if0.snd_dout !== 8'h02) begin bad++; $display("FAIL b2b_head got=%h exp=02", if0.snd_dout); end
      total++;
      set_we(0, 1'b0, 8'h55);
      tick(2);
      for (int i = 0; i < 4; i++) begin
         pop(0, v);
         if (v !== exp_q[i]) begin bad++; $display("FAIL b2b_pop_%0d got=%h exp=%h", i, v, exp_q[i]); end
         total++;
      end
      if (if0.snd_dout !== 8'hFF) begin bad++; $display("FAIL b2b_empty got=%h exp=ff", if0.snd_dout); end
      total++;
   endtask

   task automatic test_level_irq();
      logic [7:0] v;
      do_reset();
      if (if1.int_n !== 1'b1) begin bad++; $display("FAIL lvl_rst got=%b exp=1", if1.int_n); end
      total++;
      set_we(1, 1'b1, 8'hA5);
      tick(1);
      if (if1.int_n !== 1'b1) begin bad++; $display("FAIL lvl_lag got=%b exp=1", if1.int_n); end
      total++;
      tick(1);
      if (if1.int_n !== 1'b0) begin bad++; $display("FAIL lvl_set got=%b exp=0", if1.int_n); end
      total++;
      set_we(1, 1'b0, 8'hA5);
      tick(2);
      if1.irq_ack = 1'b1;
      tick(1);
      if1.irq_ack = 1'b0;
      tick(1);
      if (if1.int_n !== 1'b0) begin bad++; $display("FAIL lvl_ack_ignored got=%b exp=0", if1.int_n); end
      total++;
      set_rd(1, 1'b1);
      tick(1);
      v = if1.snd_dout;
      if (v !== 8'hA5) begin bad++; $display("FAIL lvl_head got=%h exp=a5", v); end
      total++;
      tick(1);
      set_rd(1, 1'b0);
      tick(1);
      if (if1.int_n !== 1'b0) begin bad++; $display("FAIL lvl_clear_lag got=%b exp=0", if1.int_n); end
      total++;
      tick(1);
      if (if1.int_n !== 1'b1) begin bad++; $display("FAIL lvl_clear got=%b exp=1", if1.int_n); end
      total++;
   endtask

   task automatic test_reply();
      do_reset();
      if0.snd_din = 8'h5A;
      if0.snd_we  = 1'b1;
      tick(1);
      if (if0.main_dout !== 8'h5A || if0.main_rdy !== 1'b1) begin bad++; $display("FAIL reply_write got=%h/%b exp=5a/1", if0.main_dout, if0.main_rdy); end
      total++;
      if0.snd_we = 1'b0;
      tick(2);
      if0.main_rd = 1'b1;
      tick(2);
      if0.main_rd = 1'b0;
      tick(1);
      if (if0.main_rdy !== 1'b0 || if0.main_dout !== 8'h5A) begin bad++; $display("FAIL reply_read got=%b/%h exp=0/5a", if0.main_rdy, if0.main_dout); end
      total++;
      if0.main_rd = 1'b1;
      tick(2);
      if0.main_rd = 1'b0;
      if0.snd_din = 8'h3C;
      if0.snd_we  = 1'b1;
      tick(1);
      if (if0.main_rdy !== 1'b1 || if0.main_dout !== 8'h3C) begin bad++; $display("FAIL reply_collide got=%b/%h exp=1/3c", if0.main_rdy, if0.main_dout); end
      total++;
      if0.snd_we = 1'b0;
      tick(2);
      if (if0.main_rdy !== 1'b1) begin bad++; $display("FAIL reply_hold got=%b exp=1", if0.main_rdy); end
      total++;
   endtask

   task automatic test_latch_and_rst();
      do_reset();
      if (if2.snd_status !== 3'b001 || if2.snd_dout !== 8'hFF) begin bad++; $display("FAIL aw0_rst got=%b/%h exp=001/ff", if2.snd_status, if2.snd_dout); end
      total++;
      push(2, 8'h77);
      if (if2.snd_status !== 3'b010 || if2.snd_dout !== 8'h77 || if2.main_full !== 1'b1) begin bad++; $display("FAIL aw0_push got=%b/%h/%b exp=010/77/1", if2.snd_status, if2.snd_dout, if2.main_full); end
      total++;
      push(2, 8'h88);
      if (if2.snd_status !== 3'b110 || if2.snd_dout !== 8'h77) begin bad++; $display("FAIL aw0_ovf got=%b/%h exp=110/77", if2.snd_status, if2.snd_dout); end
      total++;
      if (if2.int_n !== 1'b0) begin bad++; $display("FAIL aw0_irq got=%b exp=0", if2.int_n); end
      total++;
      if0.snd_din = 8'hC3;
      if0.snd_we  = 1'b1;
      tick(2);
      if0.snd_we = 1'b0;
      set_we(2, 1'b1, 8'h99);
      tick(1);
      rst = 1'b1;
      #1;
      if (if2.snd_status !== 3'b001 || if2.snd_dout !== 8'hFF || if2.int_n !== 1'b1 || if2.main_full !== 1'b0) begin bad++; $display("FAIL async_rst got=%b/%h/%b/%b exp=001/ff/1/0", if2.snd_status, if2.snd_dout, if2.int_n, if2.main_full); end
      total++;
      if (if0.main_rdy !== 1'b0 || if0.main_dout !== 8'h00) begin bad++; $display("FAIL async_rst_reply got=%b/%h exp=0/00", if0.main_rdy, if0.main_dout); end
      total++;
      tick(1);
      rst = 1'b0;
      tick(3);
      if (if2.snd_status !== 3'b001 || if2.snd_dout !== 8'hFF) begin bad++; $display("FAIL rst_no_partial got=%b/%h exp=001/ff", if2.snd_status, if2.snd_dout); end
      total++;
      set_we(2, 1'b0, 8'h99);
      tick(2);
      if (if2.snd_status !== 3'b001 || if2.int_n !== 1'b1) begin bad++; $display("FAIL rst_release got=%b/%b exp=001/1", if2.snd_status, if2.int_n); end
      total++;
   endtask

   initial begin
      clear_all();
      test_reset();
      test_push_pop_irq();
      test_overflow();
      test_back_to_back();
      test_level_irq();
      test_reply();
      test_latch_and_rst();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
